core_out_arbiter: RTL and testbench
===================================

# core_out_arbiter

- Clocked arbiter that shares the core's single 11-bit output link between two requesters:
  - the local data generator (8-bit, Hamming-encoded on entry);
  - the router ingress (11-bit, passed through).
- Weighted round-robin with a registered output stage and valid/ready handshakes.
- Reports the winning source on every transfer, so downstream routing can tell locally injected flits from forwarded ones.
- Sits between the data generator, the router input port and the core's outbound link.

## Interface
- WEIGHT, 1: max consecutive grants to one source while the other is also requesting (1..15).
- STAT_W, 16: width of the per-source grant counters.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- dg_valid  in  1  local byte offered.
- dg_data  in  8  local byte.
- dg_ready  out  1  local byte accepted this cycle when high with dg_valid.
- rt_valid  in  1  router flit offered.
- rt_data  in  11  router flit.
- rt_ready  out  1  router flit accepted this cycle when high with rt_valid.
- out_valid  out  1  output register holds a flit.
- out_data  out  11  output flit.
- out_src  out  1  0 = local, 1 = router.
- out_ready  in  1  downstream accepts the flit when high with out_valid.
- stat_dg_cnt  out  STAT_W  grants to local.
- stat_rt_cnt  out  STAT_W  grants to router.

## Operation
- Output stage: one register holding out_data and out_src.
  - load = out_ready || !out_valid.
  - No input is accepted unless load is high.
- Arbitration, evaluated combinationally each cycle when load=1:
  - Only one source valid: grant that source.
  - Both valid and run_cnt < WEIGHT: grant last_src.
  - Both valid and run_cnt >= WEIGHT: grant the other source.
  - Neither valid: no grant; out_valid clears if out_ready.
- ready outputs:
  - dg_ready = load && grant==local.
  - rt_ready = load && grant==router.
  - Never both high.
  - Each is independent of that source's own valid apart from the grant decision.
- Bookkeeping on every grant:
  - run_cnt becomes 1 if the grant differs from last_src.
  - Otherwise run_cnt increments, saturating at 15.
  - last_src becomes the granted source.
- Local encoding (Hamming 7,4 on dg_data[7:4]; low nibble unprotected header):
  - out[3:0]=d[3:0]
  - out[6]=d[4], out[8]=d[5], out[9]=d[6], out[10]=d[7]
  - out[4]=d4^d5^d7
  - out[5]=d4^d6^d7
  - out[7]=d5^d6^d7
- Router flits are loaded unchanged.
- State machine: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on grant.
  - FULL->FULL on out_ready with grant, or on !out_ready (stall; data held stable).
  - FULL->EMPTY on out_ready with no grant.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - last_src=1, run_cnt=WEIGHT, so the first tie goes to local.
  - Stat counters=0.
  - dg_ready and rt_ready: =1 during reset whenever the corresponding valid is high, since load=1.
- Latency: an input accepted at edge N appears on out_* after edge N; out_valid is high in cycle N+1.
- Throughput: one flit per cycle with out_ready held high.
- Backpressure:
  - out_valid=1 && !out_ready: both ready outputs low.
  - out_data and out_src hold stable.
  - Arbitration state is frozen.
- Simultaneous drain and load in the same cycle is legal and produces no bubble.
- Input sources must hold valid and data stable until accepted. The arbiter never drops or duplicates a flit.
- Reset mid-transfer:
  - A held flit is discarded.
  - Stats clear.
  - Arbitration restarts with local priority.
- WEIGHT=1 reproduces strict alternation under continuous contention: L,R,L,R...

## Configuration
- CORE_ARB_STATS_EN defined:
  - stat_dg_cnt and stat_rt_cnt increment by 1 on each grant to their source.
  - Both saturate at all-ones.
- CORE_ARB_STATS_EN undefined:
  - Counters are not built.
  - Both stat outputs are tied to 0.
  - Arbitration is identical.

## Test plan
- Reset, then dg_valid with dg_data=8'h15 and out_ready=1 -> next cycle out_valid=1, out_data=11'h075, out_src=0.
- rt_valid only, rt_data=11'h5A3 -> out_data=11'h5A3, out_src=1, one cycle latency; dg_ready stays low.
- Both valid continuously, WEIGHT=1, dg=8'hF0 -> out sequence 11'h7F0(src0), rt(src1), 11'h7F0(src0)... alternating; first grant is local.
- Both valid, WEIGHT=3 -> grants L,L,L,R,R,R,L repeating.
- out_ready low for 5 cycles while FULL -> out_data stable, both ready low, no grants counted; on release, flits resume back-to-back with no bubble.
- CORE_ARB_STATS_EN, 10 local and 7 router grants -> stat_dg_cnt=10, stat_rt_cnt=7. Then assert rst_n=0 mid-stall -> out_valid=0 immediately and counters=0.

Source files
------------

// File: rtl/core_out_arbiter.sv
// Two-source weighted round-robin arbiter for the core's 11-bit outbound link.
// Optional per-source grant counters are built when CORE_ARB_STATS_EN is defined.
module core_out_arbiter #(
  parameter int WEIGHT = 1,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dg_valid,
  input  logic [7:0]        dg_data,
  output logic              dg_ready,
  input  logic              rt_valid,
  input  logic [10:0]       rt_data,
  output logic              rt_ready,
  output logic              out_valid,
  output logic [10:0]       out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [STAT_W-1:0] stat_dg_cnt,
  output logic [STAT_W-1:0] stat_rt_cnt
);

  localparam logic       SRC_DG   = 1'b0;
  localparam logic       SRC_RT   = 1'b1;
  localparam logic [3:0] WEIGHT_L = 4'(WEIGHT);
  localparam logic [3:0] RUN_MAX  = 4'hF;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t      state_reg;
  logic [10:0] out_data_reg;
  logic        out_src_reg;
  logic        last_src_reg;
  logic [3:0]  run_cnt_reg;

  logic        load;
  logic        grant_valid;
  logic        grant_src;
  logic        take;
  logic [10:0] dg_enc;
  logic [10:0] load_data;

  // Hamming(7,4) over the high nibble; the low nibble is an unprotected header.
  function automatic logic [10:0] hamming_enc(input logic [7:0] d);
    logic [10:0] e;
    e[3:0] = d[3:0];
    e[4]   = d[4] ^ d[5] ^ d[7];
    e[5]   = d[4] ^ d[6] ^ d[7];
    e[6]   = d[4];
    e[7]   = d[5] ^ d[6] ^ d[7];
    e[8]   = d[5];
    e[9]   = d[6];
    e[10]  = d[7];
    return e;
  endfunction

  assign dg_enc = hamming_enc(dg_data);
  assign load   = out_ready || (state_reg == ST_EMPTY);

  always_comb begin
    grant_valid = dg_valid || rt_valid;
    grant_src   = SRC_DG;
    if (dg_valid && rt_valid) begin
      // Stay with the current owner until its run reaches WEIGHT.
      grant_src = (run_cnt_reg < WEIGHT_L) ? last_src_reg : ~last_src_reg;
    end else if (rt_valid) begin
      grant_src = SRC_RT;
    end
  end

  assign take      = load && grant_valid;
  assign dg_ready  = take && (grant_src == SRC_DG);
  assign rt_ready  = take && (grant_src == SRC_RT);
  assign load_data = (grant_src == SRC_RT) ? rt_data : dg_enc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      out_data_reg <= '0;
      out_src_reg  <= SRC_DG;
      last_src_reg <= SRC_RT;
      run_cnt_reg  <= WEIGHT_L;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (take) begin
            state_reg    <= ST_FULL;
            out_data_reg <= load_data;
            out_src_reg  <= grant_src;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (take) begin
              out_data_reg <= load_data;
              out_src_reg  <= grant_src;
            end else begin
              state_reg <= ST_EMPTY;
            end
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase

      if (take) begin
        last_src_reg <= grant_src;
        if (grant_src != last_src_reg) begin
          run_cnt_reg <= 4'd1;
        end else if (run_cnt_reg != RUN_MAX) begin
          run_cnt_reg <= run_cnt_reg + 4'd1;
        end
      end
    end
  end

  assign out_valid = (state_reg == ST_FULL);
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

`ifdef CORE_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt_reg [2];

  // Index 0 counts local grants, index 1 router grants.
  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stat_cnt_reg[gi] <= '0;
      end else if (take && (grant_src == 1'(gi)) && (stat_cnt_reg[gi] != '1)) begin
        stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 1'b1;
      end
    end
  end

  assign stat_dg_cnt = stat_cnt_reg[0];
  assign stat_rt_cnt = stat_cnt_reg[1];
`else
  assign stat_dg_cnt = '0;
  assign stat_rt_cnt = '0;
`endif

endmodule

// File: tb/tb_core_out_arbiter.sv
// Directed bench for core_out_arbiter: one instance at WEIGHT=1, one at WEIGHT=3.
`timescale 1ns/1ps
module tb_core_out_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dg_valid;
  logic [7:0]  dg_data;
  logic        rt_valid;
  logic [10:0] rt_data;
  logic        out_ready;

  logic        w1_dg_ready, w1_rt_ready, w1_out_valid, w1_out_src;
  logic [10:0] w1_out_data;
  logic [15:0] w1_stat_dg, w1_stat_rt;
  logic        w3_dg_ready, w3_rt_ready, w3_out_valid, w3_out_src;
  logic [10:0] w3_out_data;
  logic [15:0] w3_stat_dg, w3_stat_rt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  core_out_arbiter #(.WEIGHT(1), .STAT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .dg_valid(dg_valid), .dg_data(dg_data), .dg_ready(w1_dg_ready),
    .rt_valid(rt_valid), .rt_data(rt_data), .rt_ready(w1_rt_ready),
    .out_valid(w1_out_valid), .out_data(w1_out_data), .out_src(w1_out_src),
    .out_ready(out_ready),
    .stat_dg_cnt(w1_stat_dg), .stat_rt_cnt(w1_stat_rt)
  );

  core_out_arbiter #(.WEIGHT(3), .STAT_W(16)) u_w3 (
    .clk(clk), .rst_n(rst_n),
    .dg_valid(dg_valid), .dg_data(dg_data), .dg_ready(w3_dg_ready),
    .rt_valid(rt_valid), .rt_data(rt_data), .rt_ready(w3_rt_ready),
    .out_valid(w3_out_valid), .out_data(w3_out_data), .out_src(w3_out_src),
    .out_ready(out_ready),
    .stat_dg_cnt(w3_stat_dg), .stat_rt_cnt(w3_stat_rt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [10:0] exp_data;
  logic        exp_src;
  logic [31:0] exp_dg_stat, exp_rt_stat;

  initial begin
    rst_n = 1'b0; dg_valid = 1'b1; dg_data = 8'h15;
    rt_valid = 1'b0; rt_data = '0; out_ready = 1'b0;

    // Reset state; ready follows valid because load is high while empty.
    @(negedge clk);
    check("rst_out_valid", 32'(w1_out_valid), 32'h0);
    check("rst_out_data", 32'(w1_out_data), 32'h0);
    check("rst_out_src", 32'(w1_out_src), 32'h0);
    check("rst_dg_ready", 32'(w1_dg_ready), 32'h1);
    check("rst_rt_ready", 32'(w1_rt_ready), 32'h0);
    check("rst_stat_dg", 32'(w1_stat_dg), 32'h0);

    // Local byte 0x15 -> encoded 0x075 one cycle later.
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    dg_valid = 1'b0;
    @(negedge clk);
    check("dg_out_valid", 32'(w1_out_valid), 32'h1);
    check("dg_out_data", 32'(w1_out_data), 32'h075);
    check("dg_out_src", 32'(w1_out_src), 32'h0);

    // Router flit passes through unchanged.
    rt_valid = 1'b1; rt_data = 11'h5A3;
    #1;
    check("rt_ready_hi", 32'(w1_rt_ready), 32'h1);
    check("rt_dg_ready_lo", 32'(w1_dg_ready), 32'h0);
    @(posedge clk); #1;
    rt_valid = 1'b0;
    @(negedge clk);
    check("rt_out_data", 32'(w1_out_data), 32'h5A3);
    check("rt_out_src", 32'(w1_out_src), 32'h1);
    cycle();
    check("drain_empty", 32'(w1_out_valid), 32'h0);

    // Continuous contention: WEIGHT=1 alternates, WEIGHT=3 goes LLLRRR.
    do_reset();
    dg_valid = 1'b1; dg_data = 8'hF0; rt_valid = 1'b1; rt_data = 11'h123;
    for (int i = 0; i < 12; i++) begin
      cycle();
      exp_src  = 1'(i % 2);
      exp_data = exp_src ? 11'h123 : 11'h7F0;
      check($sformatf("w1_src[%0d]", i), 32'(w1_out_src), 32'(exp_src));
      check($sformatf("w1_data[%0d]", i), 32'(w1_out_data), 32'(exp_data));
      check($sformatf("w3_src[%0d]", i), 32'(w3_out_src), 32'((i / 3) % 2));
    end

    // Stall five cycles: output held, readies low, arbitration frozen.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_dg_ready[%0d]", i), 32'(w1_dg_ready), 32'h0);
      check($sformatf("stall_rt_ready[%0d]", i), 32'(w1_rt_ready), 32'h0);
      cycle();
      check($sformatf("stall_data[%0d]", i), 32'(w1_out_data), 32'h123);
      check($sformatf("stall_w3_src[%0d]", i), 32'(w3_out_src), 32'h1);
    end
    out_ready = 1'b1;
    for (int i = 12; i < 16; i++) begin
      cycle();
      check($sformatf("resume_valid[%0d]", i), 32'(w1_out_valid), 32'h1);
      check($sformatf("resume_w1_src[%0d]", i), 32'(w1_out_src), 32'(i % 2));
      check($sformatf("resume_w3_src[%0d]", i), 32'(w3_out_src), 32'((i / 3) % 2));
    end

    // 10 local and 7 router grants on the WEIGHT=1 instance.
    do_reset();
    for (int i = 0; i < 14; i++) cycle();
    rt_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    dg_valid = 1'b0; out_ready = 1'b0;
    cycle();
`ifdef CORE_ARB_STATS_EN
    exp_dg_stat = 32'd10; exp_rt_stat = 32'd7;
`else
    exp_dg_stat = 32'd0; exp_rt_stat = 32'd0;
`endif
    check("stat_dg", 32'(w1_stat_dg), exp_dg_stat);
    check("stat_rt", 32'(w1_stat_rt), exp_rt_stat);
    check("pre_rst_valid", 32'(w1_out_valid), 32'h1);
    check("pre_rst_src", 32'(w1_out_src), 32'h0);

    // Asynchronous reset mid-stall.
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(w1_out_valid), 32'h0);
    check("arst_stat_dg", 32'(w1_stat_dg), 32'h0);
    check("arst_stat_rt", 32'(w1_stat_rt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset a tie goes to local first.
    dg_valid = 1'b1; rt_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("post_rst_dg_ready", 32'(w1_dg_ready), 32'h1);
    cycle();
    check("post_rst_src", 32'(w1_out_src), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
